// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises request lines, latches edge/level requests,
// applies per-source enables and drives a registered irq, with an MMIO window for claim/ack.
module irq_ctrl #(
    parameter int NSRC        = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NSRC-1:0] src,
    input  logic            bus_req,
    input  logic            bus_we,
    input  logic [3:0]      bus_addr,
    input  logic [31:0]     bus_wdata,
    output logic [31:0]     bus_rdata,
    output logic            bus_rvalid,
    output logic            irq
);

    // Bus handshake: a request is accepted on every rising edge where bus_req is high;
    // an accepted read returns bus_rdata with bus_rvalid high exactly one cycle later.
    localparam logic [1:0] REG_PEND  = 2'd0;
    localparam logic [1:0] REG_EN    = 2'd1;
    localparam logic [1:0] REG_MODE  = 2'd2;
    localparam logic [1:0] REG_CLAIM = 2'd3;

    logic [NSRC-1:0] sync_q [SYNC_STAGES];
    logic [NSRC-1:0] s;
    logic [NSRC-1:0] s_d;
    logic [NSRC-1:0] edge_q;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] en;
    logic [NSRC-1:0] mode;

    logic [NSRC-1:0] pend_next;
    logic [NSRC-1:0] clr;
    logic [NSRC-1:0] claim_oh;
    logic            claim_valid;
    logic [4:0]      claim_id;
    logic [31:0]     rd_word;
    logic            rd_acc;
    logic            wr_acc;
    logic [1:0]      sel;

    assign s      = sync_q[SYNC_STAGES-1];
    assign rd_acc = bus_req & ~bus_we;
    assign wr_acc = bus_req & bus_we;
    assign sel    = bus_addr[3:2];

    // Lowest qualifying index wins: scan downwards so the last hit is the smallest.
    always_comb begin
        claim_valid = 1'b0;
        claim_id    = 5'd0;
        claim_oh    = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pend[i] && en[i]) begin
                claim_valid = 1'b1;
                claim_id    = 5'(i);
                claim_oh    = NSRC'(1) << i;
            end
        end
    end

    // Edge-mode bits clear on W1C or claim, but a same-cycle edge re-sets them.
    always_comb begin
        clr = '0;
        if (wr_acc && sel == REG_PEND) begin
            clr = bus_wdata[NSRC-1:0];
        end
        if (rd_acc && sel == REG_CLAIM && claim_valid) begin
            clr = clr | claim_oh;
        end
        pend_next = (mode & ((pend & ~clr) | edge_q)) | (~mode & s);
    end

    always_comb begin
        rd_word = '0;
        case (sel)
            REG_PEND:  rd_word = 32'(pend);
            REG_EN:    rd_word = 32'(en);
            REG_MODE:  rd_word = 32'(mode);
            REG_CLAIM: rd_word = {claim_valid, 26'b0, claim_id};
            default:   rd_word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            s_d        <= '0;
            edge_q     <= '0;
            pend       <= '0;
            en         <= '0;
            mode       <= '0;
            irq        <= 1'b0;
            bus_rdata  <= '0;
            bus_rvalid <= 1'b0;
        end else begin
            sync_q[0] <= src;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            s_d    <= s;
            // Edge pulse is registered once before reaching PEND.
            edge_q <= s & ~s_d;
            pend   <= pend_next;
            irq    <= |(pend & en);
            if (wr_acc && sel == REG_EN) begin
                en <= bus_wdata[NSRC-1:0];
            end
            if (wr_acc && sel == REG_MODE) begin
                mode <= bus_wdata[NSRC-1:0];
            end
            bus_rvalid <= rd_acc;
            if (rd_acc) begin
                bus_rdata <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: latency, claim order, level/edge behaviour,
// set-wins on W1C, enable gating and mid-access reset.
module tb_irq_ctrl;

    localparam int NSRC        = 8;
    localparam int SYNC_STAGES = 2;

    logic            clk;
    logic            rst_n;
    logic [NSRC-1:0] src;
    logic            bus_req;
    logic            bus_we;
    logic [3:0]      bus_addr;
    logic [31:0]     bus_wdata;
    logic [31:0]     bus_rdata;
    logic            bus_rvalid;
    logic            irq;

    int          tests;
    int          fails;
    logic [31:0] rd;

    irq_ctrl #(.NSRC(NSRC), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src        (src),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_rvalid (bus_rvalid),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // All drivers start and end on a falling edge.
    task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = addr;
        bus_wdata = data;
        @(posedge clk);
        @(negedge clk);
        bus_req   = 1'b0;
        bus_we    = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] addr, output logic [31:0] data);
        bus_req  = 1'b1;
        bus_we   = 1'b0;
        bus_addr = addr;
        @(posedge clk);
        @(negedge clk);
        bus_req  = 1'b0;
        check("rvalid", 32'(bus_rvalid), 32'd1);
        data = bus_rdata;
    endtask

    task automatic pulse_src(input logic [NSRC-1:0] val);
        src = val;
        @(posedge clk);
        @(negedge clk);
        src = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        src       = '0;
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        idle(3);
        rst_n = 1'b1;

        // Reset state
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_rvalid", 32'(bus_rvalid), 32'd0);
        check("rst_rdata", bus_rdata, 32'd0);
        bus_read(4'h0, rd); check("rst_pend", rd, 32'd0);
        bus_read(4'h4, rd); check("rst_en", rd, 32'd0);
        bus_read(4'h8, rd); check("rst_mode", rd, 32'd0);
        bus_read(4'hC, rd); check("rst_claim", rd, 32'd0);
        // Bits above NSRC ignore writes; low address bits are ignored
        bus_write(4'h4, 32'hFFFF_FF00);
        bus_read(4'h7, rd); check("en_upper", rd, 32'd0);

        // 1: edge latency, PEND at edge 3, irq at edge 4
        bus_write(4'h4, 32'h04);
        bus_write(4'h8, 32'h04);
        pulse_src(8'h04);                 // now after edge 0
        idle(2);                          // after edge 2
        check("t1_irq_e2", 32'(irq), 32'd0);
        idle(1);                          // after edge 3
        check("t1_irq_e3", 32'(irq), 32'd0);
        idle(1);                          // after edge 4
        check("t1_irq_e4", 32'(irq), 32'd1);
        bus_read(4'h0, rd); check("t1_pend", rd, 32'h04);
        bus_write(4'h0, 32'h04);
        check("t1_wr_rvalid", 32'(bus_rvalid), 32'd0);
        check("t1_rdata_hold", bus_rdata, 32'h04);
        idle(1);
        check("t1_irq_clr", 32'(irq), 32'd0);

        // 2: two edge sources claimed lowest first
        bus_write(4'h4, 32'h28);
        bus_write(4'h8, 32'h28);
        pulse_src(8'h28);
        idle(5);
        check("t2_irq", 32'(irq), 32'd1);
        bus_read(4'hC, rd); check("t2_claim0", rd, 32'h8000_0003);
        bus_read(4'hC, rd); check("t2_claim1", rd, 32'h8000_0005);
        bus_read(4'h0, rd); check("t2_pend", rd, 32'd0);
        check("t2_irq_off", 32'(irq), 32'd0);

        // 3: level source is not sticky and ignores W1C/claim clears
        bus_write(4'h8, 32'h00);
        bus_write(4'h4, 32'h01);
        src = 8'h01;
        idle(6);
        check("t3_irq", 32'(irq), 32'd1);
        bus_read(4'hC, rd); check("t3_claim0", rd, 32'h8000_0000);
        bus_read(4'hC, rd); check("t3_claim1", rd, 32'h8000_0000);
        bus_write(4'h0, 32'h01);
        bus_read(4'h0, rd); check("t3_pend_w1c", rd, 32'h01);
        src = '0;
        idle(SYNC_STAGES + 2);
        check("t3_irq_off", 32'(irq), 32'd0);
        bus_read(4'h0, rd); check("t3_pend_off", rd, 32'd0);

        // 4: W1C landing in the same cycle as the PEND set, set wins
        bus_write(4'h4, 32'h02);
        bus_write(4'h8, 32'h02);
        pulse_src(8'h02);                 // after edge 0
        idle(2);                          // after edge 2
        bus_write(4'h0, 32'h02);          // accepted at edge 3
        bus_read(4'h0, rd); check("t4_set_wins", rd, 32'h02);
        bus_write(4'h0, 32'h02);
        bus_read(4'h0, rd); check("t4_w1c", rd, 32'd0);

        // 5: enable gating
        bus_write(4'h4, 32'h00);
        bus_write(4'h8, 32'h10);
        pulse_src(8'h10);
        idle(6);
        check("t5_irq_masked", 32'(irq), 32'd0);
        bus_read(4'hC, rd); check("t5_claim", rd, 32'd0);
        bus_read(4'h0, rd); check("t5_pend", rd, 32'h10);
        bus_write(4'h4, 32'h10);
        check("t5_irq_same", 32'(irq), 32'd0);
        idle(1);
        check("t5_irq_next", 32'(irq), 32'd1);

        // 6: reset mid-read drops the response and clears everything
        bus_req  = 1'b1;
        bus_we   = 1'b0;
        bus_addr = 4'h0;
        rst_n    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus_req = 1'b0;
        rst_n   = 1'b1;
        check("t6_rvalid", 32'(bus_rvalid), 32'd0);
        check("t6_rdata", bus_rdata, 32'd0);
        check("t6_irq", 32'(irq), 32'd0);
        bus_read(4'h0, rd); check("t6_pend", rd, 32'd0);
        bus_read(4'h4, rd); check("t6_en", rd, 32'd0);
        bus_read(4'h8, rd); check("t6_mode", rd, 32'd0);
        bus_read(4'hC, rd); check("t6_claim", rd, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
